// File: rtl/ps2_key_txt.sv
// PS/2 keyboard front end for the probe text console: receives device-to-host
// frames, decodes make codes to ASCII and tracks the entry cursor column.
module ps2_key_txt #(
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int MAX_XLOC    = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic       ASCII_EN,
  output logic [6:0] ASCII,
  output logic [6:0] XLOC,
  output logic       K_ENTER,
  output logic       CLR_XPOS,
  output logic       FRM_ERR
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;
  typedef enum logic [2:0] {KEY_NONE, KEY_PRINT, KEY_ENTER, KEY_BKSP, KEY_ESC} key_t;

  logic [1:0]    clk_sync, dat_sync;
  logic          s_clk, s_dat;
  logic [FW-1:0] filt_cnt;
  logic          filt_clk;
  logic          fall;

  rx_state_t     state, state_nxt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bit;
  logic [TW-1:0] tmo_cnt;
  logic          tmo;
  logic          frame_ok, frame_bad;
  logic          code_vld;
  logic [7:0]    code;

  logic          ext, brk;
  logic [6:0]    xpos;
  key_t          key;
  logic [6:0]    key_ch;

  assign s_clk = clk_sync[1];
  assign s_dat = dat_sync[1];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[0], PS2_CLK};
      dat_sync <= {dat_sync[0], PS2_DAT};
    end
  end

  // The filtered level flips on the FILT_LEN-th consecutive differing sample.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      filt_cnt <= '0;
      filt_clk <= 1'b1;
    end else if (s_clk == filt_clk) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
      filt_cnt <= '0;
      filt_clk <= s_clk;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign fall = filt_clk && !s_clk && (filt_cnt == FW'(FILT_LEN - 1));

  // A fall on the terminal count wins over the timeout.
  assign tmo = (state != IDLE) && !fall && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    case (state)
      IDLE:   if (fall && !s_dat) state_nxt = DATA;
      DATA:   if (fall && bit_cnt == 3'd7) state_nxt = PARITY;
      PARITY: if (fall) state_nxt = STOP;
      STOP: begin
        if (fall) begin
          state_nxt = IDLE;
          if (s_dat && (^{par_bit, shift})) frame_ok  = 1'b1;
          else                              frame_bad = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (tmo) state_nxt = IDLE;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      tmo_cnt  <= '0;
      code_vld <= 1'b0;
      code     <= '0;
      FRM_ERR  <= 1'b0;
    end else begin
      if (state == IDLE) begin
        bit_cnt <= '0;
      end else if (fall && state == DATA) begin
        shift   <= {s_dat, shift[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end else if (fall && state == PARITY) begin
        par_bit <= s_dat;
      end

      if (fall || state == IDLE) tmo_cnt <= '0;
      else if (!tmo)             tmo_cnt <= tmo_cnt + 1'b1;

      code_vld <= frame_ok;
      if (frame_ok) code <= shift;
      FRM_ERR <= frame_bad | tmo;
    end
  end

  always_comb begin
    key    = KEY_PRINT;
    key_ch = '0;
    case (code)
      8'h45: key_ch = 7'h30;
      8'h16: key_ch = 7'h31;
      8'h1E: key_ch = 7'h32;
      8'h26: key_ch = 7'h33;
      8'h25: key_ch = 7'h34;
      8'h2E: key_ch = 7'h35;
      8'h36: key_ch = 7'h36;
      8'h3D: key_ch = 7'h37;
      8'h3E: key_ch = 7'h38;
      8'h46: key_ch = 7'h39;
      8'h1C: key_ch = 7'h41;
      8'h32: key_ch = 7'h42;
      8'h21: key_ch = 7'h43;
      8'h23: key_ch = 7'h44;
      8'h24: key_ch = 7'h45;
      8'h2B: key_ch = 7'h46;
      8'h34: key_ch = 7'h47;
      8'h33: key_ch = 7'h48;
      8'h43: key_ch = 7'h49;
      8'h3B: key_ch = 7'h4A;
      8'h42: key_ch = 7'h4B;
      8'h4B: key_ch = 7'h4C;
      8'h3A: key_ch = 7'h4D;
      8'h31: key_ch = 7'h4E;
      8'h44: key_ch = 7'h4F;
      8'h4D: key_ch = 7'h50;
      8'h15: key_ch = 7'h51;
      8'h2D: key_ch = 7'h52;
      8'h1B: key_ch = 7'h53;
      8'h2C: key_ch = 7'h54;
      8'h3C: key_ch = 7'h55;
      8'h2A: key_ch = 7'h56;
      8'h1D: key_ch = 7'h57;
      8'h22: key_ch = 7'h58;
      8'h35: key_ch = 7'h59;
      8'h1A: key_ch = 7'h5A;
      8'h5A: key = KEY_ENTER;
      8'h66: key = KEY_BKSP;
      8'h76: key = KEY_ESC;
      default: key = KEY_NONE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ext      <= 1'b0;
      brk      <= 1'b0;
      xpos     <= 7'd1;
      ASCII_EN <= 1'b0;
      ASCII    <= '0;
      XLOC     <= '0;
      K_ENTER  <= 1'b0;
      CLR_XPOS <= 1'b0;
    end else begin
      ASCII_EN <= 1'b0;
      K_ENTER  <= 1'b0;
      CLR_XPOS <= 1'b0;
      if (code_vld) begin
        if (code == 8'hE0) begin
          ext <= 1'b1;
        end else if (code == 8'hF0) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (!ext && !brk) begin
            case (key)
              KEY_PRINT: begin
                if (xpos <= 7'(MAX_XLOC)) begin
                  ASCII_EN <= 1'b1;
                  ASCII    <= key_ch;
                  XLOC     <= xpos;
                  xpos     <= xpos + 7'd1;
                end
              end
              KEY_BKSP: if (xpos > 7'd1) xpos <= xpos - 7'd1;
              KEY_ESC: begin
                CLR_XPOS <= 1'b1;
                xpos     <= 7'd1;
              end
              KEY_ENTER: K_ENTER <= 1'b1;
              default: ;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_txt.sv
// Scoreboard bench for ps2_key_txt: frames are bit-banged on PS2_CLK/PS2_DAT,
// expected strobes are queued up front and matched as the DUT emits them.
module tb_ps2_key_txt;

  localparam int TMO = 1000;

  localparam int EV_CHAR  = 1;
  localparam int EV_ENTER = 2;
  localparam int EV_CLR   = 3;
  localparam int EV_ERR   = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DAT = 1'b1;
  logic       ASCII_EN, K_ENTER, CLR_XPOS, FRM_ERR;
  logic [6:0] ASCII, XLOC;

  typedef struct {
    int kind;
    int ch;
    int x;
  } ev_t;

  ev_t q[$];
  int  n_chk  = 0;
  int  n_fail = 0;

  ps2_key_txt #(.FILT_LEN(8), .TIMEOUT_CYC(TMO), .MAX_XLOC(3)) dut (
    .CLK(CLK), .RST(RST), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
    .ASCII_EN(ASCII_EN), .ASCII(ASCII), .XLOC(XLOC),
    .K_ENTER(K_ENTER), .CLR_XPOS(CLR_XPOS), .FRM_ERR(FRM_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic exp_ch(input int ch, input int x);
    ev_t e;
    e.kind = EV_CHAR; e.ch = ch; e.x = x;
    q.push_back(e);
  endtask

  task automatic exp_k(input int kind);
    ev_t e;
    e.kind = kind; e.ch = 0; e.x = 0;
    q.push_back(e);
  endtask

  // Sends the first n bits of a frame LSB first; data changes while clock is high.
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      PS2_DAT = bits[i];
      repeat (10) @(negedge CLK);
      PS2_CLK = 1'b0;
      repeat (20) @(negedge CLK);
      PS2_CLK = 1'b1;
      repeat (10) @(negedge CLK);
    end
    PS2_DAT = 1'b1;
  endtask

  function automatic logic [10:0] frame(input logic [7:0] c, input bit bad_par, input bit bad_stop);
    return {~bad_stop, (~^c) ^ bad_par, c, 1'b0};
  endfunction

  task automatic send(input logic [7:0] c);
    send_bits(frame(c, 1'b0, 1'b0), 11);
    repeat (30) @(negedge CLK);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 3000 && q.size() != 0; i++) @(negedge CLK);
    check(tag, q.size(), 0);
  endtask

  always @(negedge CLK) begin
    int  n;
    int  kind;
    ev_t e;
    if (!RST) begin
      n = int'(ASCII_EN) + int'(K_ENTER) + int'(CLR_XPOS) + int'(FRM_ERR);
      if (n > 0) begin
        check("excl", n, 1);
        kind = ASCII_EN ? EV_CHAR : K_ENTER ? EV_ENTER : CLR_XPOS ? EV_CLR : EV_ERR;
        if (q.size() == 0) begin
          check("unexpected_strobe", kind, 0);
        end else begin
          e = q.pop_front();
          check("kind", kind, e.kind);
          if (kind == EV_CHAR) begin
            check("ascii", int'(ASCII), e.ch);
            check("xloc", int'(XLOC), e.x);
          end
        end
      end
    end
  end

  initial begin
    #900us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge CLK);
    check("rst_ascii_en", int'(ASCII_EN), 0);
    check("rst_ascii", int'(ASCII), 0);
    check("rst_xloc", int'(XLOC), 0);
    check("rst_strobes", int'({K_ENTER, CLR_XPOS, FRM_ERR}), 0);
    RST = 1'b0;
    repeat (20) @(negedge CLK);

    // Fill the line, then overflow column MAX_XLOC+1
    exp_ch(8'h31, 1); exp_ch(8'h32, 2); exp_ch(8'h33, 3);
    send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
    exp_k(EV_CLR);
    send(8'h76);
    drain("drain_fill");

    // Break and extended prefixes suppress output
    exp_ch(8'h41, 1); exp_k(EV_ENTER);
    send(8'h1C); send(8'hF0); send(8'h1C); send(8'hE0); send(8'h5A); send(8'h5A);
    exp_k(EV_CLR);
    send(8'h76);
    drain("drain_prefix");

    // Backspace, Esc, and backspace at the lower bound
    exp_ch(8'h31, 1); exp_ch(8'h32, 2); exp_ch(8'h33, 2);
    send(8'h16); send(8'h1E); send(8'h66); send(8'h26);
    exp_k(EV_CLR); exp_ch(8'h30, 1);
    send(8'h76); send(8'h45);
    exp_ch(8'h32, 1);
    send(8'h66); send(8'h66); send(8'h66); send(8'h1E);
    drain("drain_cursor");

    // Parity and stop-bit errors, then letters at columns 2 and 3
    exp_k(EV_ERR); exp_k(EV_ERR);
    send_bits(frame(8'h16, 1'b1, 1'b0), 11); repeat (30) @(negedge CLK);
    send_bits(frame(8'h16, 1'b0, 1'b1), 11); repeat (30) @(negedge CLK);
    exp_ch(8'h46, 2); exp_ch(8'h5A, 3);
    send(8'h2B); send(8'h1A);
    drain("drain_err");

    // Partial frame timeout, then a clean frame
    exp_k(EV_CLR); exp_k(EV_ERR); exp_ch(8'h30, 1);
    send(8'h76);
    send_bits(frame(8'h45, 1'b0, 1'b0), 4);
    repeat (TMO + 100) @(negedge CLK);
    send(8'h45);
    drain("drain_tmo");

    // Short low glitches with data low must not start a frame
    for (int w = 1; w <= 3; w++) begin
      PS2_DAT = 1'b0;
      PS2_CLK = 1'b0;
      repeat (w) @(negedge CLK);
      PS2_CLK = 1'b1;
      repeat (40) @(negedge CLK);
    end
    PS2_DAT = 1'b1;
    repeat (TMO + 100) @(negedge CLK);
    exp_ch(8'h32, 2);
    send(8'h1E);
    drain("drain_glitch");

    // Reset mid-frame with a pending break flag
    send(8'hF0);
    send_bits(frame(8'h26, 1'b0, 1'b0), 5);
    RST = 1'b1;
    @(negedge CLK);
    check("mid_rst_ascii", int'(ASCII), 0);
    check("mid_rst_xloc", int'(XLOC), 0);
    check("mid_rst_strobes", int'({ASCII_EN, K_ENTER, CLR_XPOS, FRM_ERR}), 0);
    PS2_CLK = 1'b1;
    PS2_DAT = 1'b1;
    repeat (5) @(negedge CLK);
    RST = 1'b0;
    repeat (20) @(negedge CLK);
    exp_ch(8'h31, 1);
    send(8'h16);
    drain("drain_rst");

    repeat (50) @(negedge CLK);
    check("hold_ascii", int'(ASCII), 8'h31);
    check("hold_xloc", int'(XLOC), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_key_txt.md
# ps2_key_txt

Keyboard front end for the probe text console. It receives PS/2 device-to-host frames and decodes make codes to 7-bit ASCII. It tracks the entry cursor column and drives the ASCII_EN / ASCII / XLOC / K_ENTER / CLR_XPOS inputs of the downstream probe-text stage, which builds the probe ID and launches the flash page read.

## Interface
Parameters:
- FILT_LEN, 8, consecutive identical samples required before the filtered PS/2 clock changes level
- TIMEOUT_CYC, 50000, CLK cycles without a filtered falling edge before a partial frame is aborted
- MAX_XLOC, 3, highest cursor column that accepts a printable character

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, asynchronous, active-high
- PS2_CLK  in  1  raw PS/2 clock, asynchronous
- PS2_DAT  in  1  raw PS/2 data, asynchronous
- ASCII_EN  out  1  one-cycle strobe; ASCII/XLOC valid
- ASCII  out  7  decoded character
- XLOC  out  7  column of the character strobed with ASCII_EN
- K_ENTER  out  1  one-cycle strobe, Enter make code
- CLR_XPOS  out  1  one-cycle strobe, Esc make code
- FRM_ERR  out  1  one-cycle strobe, frame error or timeout

## Operation
- **Input conditioning:** PS2_CLK and PS2_DAT each pass through a 2-FF synchronizer. The filtered clock takes a new level only after FILT_LEN equal synchronized samples. A filtered 1->0 transition is one "fall" event, and sync'd PS2_DAT is sampled on that cycle.
- **Receiver FSM:**
  - IDLE: on a fall, data=0 goes to DATA with bit count 0; data=1 is ignored (no error).
  - DATA: shifts 8 bits LSB first, then goes to PARITY.
  - PARITY: stores the parity bit, then goes to STOP.
  - STOP: on a fall, the frame is accepted only if the data bit is 1 and the 9 bits (8 data + parity) have odd parity. Acceptance produces an internal code_vld plus an 8-bit code. Any failure pulses FRM_ERR. Both cases return to IDLE.
- **Timeout:** a counter resets on every fall and runs only outside IDLE. Reaching TIMEOUT_CYC forces IDLE and pulses FRM_ERR.
- **Decoder:**
  - E0 sets ext; F0 sets brk. Neither produces output.
  - Any other code clears both flags. It produces output only if brk=0 and ext=0.
  - Typematic repeats of a make code are decoded again.
- **Map:**
  - Digits: 45->'0', 16->'1', 1E->'2', 26->'3', 25->'4', 2E->'5', 36->'6', 3D->'7', 3E->'8', 46->'9'.
  - Letters: 1C A, 32 B, 21 C, 23 D, 24 E, 2B F, 34 G, 33 H, 43 I, 3B J, 42 K, 4B L, 3A M, 31 N, 44 O, 4D P, 15 Q, 2D R, 1B S, 2C T, 3C U, 2A V, 1D W, 22 X, 35 Y, 1A Z. Letters are uppercase ASCII.
  - Control: 5A Enter, 66 Backspace, 76 Esc.
  - All other codes are ignored.
- **Cursor:** xpos is 7 bits, reset to 1.
  - Printable with xpos<=MAX_XLOC: ASCII_EN=1, ASCII=char, XLOC=xpos, then xpos+1.
  - Printable with xpos>MAX_XLOC: no strobe, xpos unchanged.
  - Backspace: xpos-1 if xpos>1, otherwise unchanged. No strobe.
  - Esc: CLR_XPOS=1 and xpos=1.
  - Enter: K_ENTER=1, xpos unchanged.
- **Mutual exclusion:** at most one of ASCII_EN, K_ENTER or CLR_XPOS is asserted in any cycle. FRM_ERR never coincides with code_vld.

## Timing
- **Reset values:**
  - ASCII_EN, K_ENTER, CLR_XPOS, FRM_ERR: 0.
  - ASCII: 0; XLOC: 0.
  - Internal state: xpos=1, FSM=IDLE, ext=brk=0, filtered clock=1.
- **Latency:**
  - Fall event: occurs 2 (sync) + FILT_LEN cycles after the raw edge.
  - code_vld: registered 1 cycle after the stop-bit fall.
  - Output strobes: asserted 1 cycle after code_vld.
- **Hold and width:** ASCII and XLOC hold their value until the next ASCII_EN. Every strobe lasts exactly 1 cycle.
- **Boundary cases:**
  - A fall coincident with the timeout terminal count is treated as a fall; no timeout occurs.
  - Reset mid-frame discards the partial frame and the pending E0/F0 flags.
  - Cursor arithmetic never wraps: the lower bound is 1 and the upper bound is MAX_XLOC+1.

## Test plan
- Frames 16, 1E, 26 (valid parity) -> three ASCII_EN strobes: ASCII 0x31/0x32/0x33 with XLOC 1/2/3. A 4th frame 25 -> no strobe.
- Sequence 1C, F0 1C, E0 5A, 5A -> ASCII_EN once with ASCII=0x41 and XLOC=1, then exactly one K_ENTER. The released A and the keypad Enter give nothing.
- Sequence 16, 1E, 66, 26 -> XLOC 1, 2, then 2 with ASCII=0x33. Then 76 -> CLR_XPOS pulse, and the next 45 gives XLOC=1, ASCII=0x30.
- Frame 16 with even parity -> FRM_ERR pulse, no ASCII_EN. A frame with stop bit 0 -> FRM_ERR.
- 4 bits then PS2_CLK held high for TIMEOUT_CYC cycles -> FRM_ERR, FSM back in IDLE. A following good 45 frame -> ASCII=0x30.
- Glitch check: a 1-3 cycle low pulse on PS2_CLK -> no fall event. RST asserted mid-frame -> all outputs 0, xpos=1, and the next full frame decodes correctly.
